// File: rtl/behav_gate_pkg.sv
// Shared definitions for the behav_gate leaf block: default vector width,
// the default vector type and the register reset values.
package behav_gate_pkg;

    localparam int BEHAV_GATE_WIDTH_DEF = 4;

    // Vectors are ascending; index 0 is the MSB.
    typedef logic [0:BEHAV_GATE_WIDTH_DEF-1] behav_gate_vec_t;

    localparam logic            Y_RST  = 1'b0;
    localparam behav_gate_vec_t VY_RST = '0;

endpackage : behav_gate_pkg

// File: rtl/behav_gate_reg.sv
// Plain D register with asynchronous active-low reset to a parameterized
// value. Used for every output flop of behav_gate.
module behav_gate_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d every rising edge; rst_n low forces the reset value at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule : behav_gate_reg

// File: rtl/behav_gate.sv
// behav_gate: registered AND-OR of four qualifier bits plus a registered
// bitwise AND of two vectors. All outputs come straight from flops.
// Optional build macro BEHAV_GATE_VPARITY_EN adds vp, the registered
// XOR-reduction of (va & vb), i.e. the parity of the next vy.
module behav_gate
    import behav_gate_pkg::*;
#(
    parameter int WIDTH = BEHAV_GATE_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic             y,
    input  logic [0:WIDTH-1] va,
    input  logic [0:WIDTH-1] vb,
    output logic [0:WIDTH-1] vy
`ifdef BEHAV_GATE_VPARITY_EN
    ,
    output logic             vp
`endif
);

    logic             y_next;
    logic [0:WIDTH-1] vy_next;

    // Next-state logic for the scalar and vector paths; index i maps to i.
    always_comb begin
        y_next  = (a & b) | (c & d);
        vy_next = va & vb;
    end

    behav_gate_reg #(
        .W       (1),
        .RST_VAL (Y_RST)
    ) u_y_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (y_next),
        .q     (y)
    );

    behav_gate_reg #(
        .W       (WIDTH),
        .RST_VAL (WIDTH'(VY_RST))
    ) u_vy_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (vy_next),
        .q     (vy)
    );

`ifdef BEHAV_GATE_VPARITY_EN
    logic vp_next;

    // Parity is taken from the same masked vector that loads vy.
    always_comb begin
        vp_next = ^vy_next;
    end

    behav_gate_reg #(
        .W       (1),
        .RST_VAL (1'b0)
    ) u_vp_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (vp_next),
        .q     (vp)
    );
`endif

endmodule : behav_gate

// File: tb/tb_behav_gate.sv
// Self-checking bench for behav_gate (WIDTH = 4): reset behaviour, a table
// of directed vectors, a mid-run asynchronous reset and random stimulus
// compared against a simple arithmetic model.
module tb_behav_gate;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         a, b, c, d;
    logic         y;
    logic [0:W-1] va, vb;
    logic [0:W-1] vy;
`ifdef BEHAV_GATE_VPARITY_EN
    logic         vp;
`endif

    int errors = 0;
    int checks = 0;

    behav_gate #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .y     (y),
        .va    (va),
        .vb    (vb),
        .vy    (vy)
`ifdef BEHAV_GATE_VPARITY_EN
        ,
        .vp    (vp)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       a, b, c, d;
        logic [3:0] va, vb;
        logic       exp_y;
        logic [3:0] exp_vy;
        logic       exp_vp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against expected values.
    task automatic chk_all(input string name, input logic ey, input logic [3:0] evy, input logic evp);
        chk({name, ".y"}, 32'(y), 32'(ey));
        chk({name, ".vy"}, 32'(vy), 32'(evy));
`ifdef BEHAV_GATE_VPARITY_EN
        chk({name, ".vp"}, 32'(vp), 32'(evp));
`else
        if (evp === 1'bx) chk({name, ".evp"}, 32'(evp), 32'(evp));
`endif
    endtask

    // Reference model: plain arithmetic from the block's rules.
    function automatic logic model_y(input logic ma, mb, mc, md);
        return (ma && mb) || (mc && md);
    endfunction

    function automatic logic model_vp(input logic [3:0] v);
        return ($countones(v) % 2) == 1;
    endfunction

    logic       prev_y;
    logic [3:0] prev_vy;
    logic       prev_vp;

    task automatic apply(input logic ia, ib, ic, id, input logic [3:0] iva, ivb);
        @(negedge clk);
        a = ia; b = ib; c = ic; d = id; va = iva; vb = ivb;
    endtask

    initial begin
        logic [3:0] mvy;
        logic       my;

        tbl.push_back('{"all_zero",   0,0,0,0, 4'b0000, 4'b0000, 0, 4'b0000, 0});
        tbl.push_back('{"and_term0",  1,1,0,0, 4'b0000, 4'b0000, 1, 4'b0000, 0});
        tbl.push_back('{"vec_mask",   1,1,0,0, 4'b1010, 4'b1111, 1, 4'b1010, 0});
        tbl.push_back('{"or_term1",   0,1,1,1, 4'b0110, 4'b1100, 1, 4'b0100, 1});
        tbl.push_back('{"term1_off",  0,1,1,0, 4'b0110, 4'b1100, 0, 4'b0100, 1});
        tbl.push_back('{"va_ones",    0,0,1,1, 4'b1111, 4'b0101, 1, 4'b0101, 0});
        tbl.push_back('{"vb_ones",    1,0,0,1, 4'b0011, 4'b1111, 0, 4'b0011, 0});
        tbl.push_back('{"all_ones",   1,1,1,1, 4'b1111, 4'b1111, 1, 4'b1111, 0});
        tbl.push_back('{"single_msb", 1,0,1,0, 4'b1000, 4'b1001, 0, 4'b1000, 1});

        // Reset held with random inputs across several edges.
        rst_n = 1'b0;
        a = 1'b1; b = 1'b1; c = 1'b1; d = 1'b1; va = 4'hF; vb = 4'hF;
        #1;
        chk_all("reset_initial", 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 1'($urandom); b = 1'($urandom); c = 1'($urandom); d = 1'($urandom);
            va = 4'($urandom); vb = 4'($urandom);
            @(posedge clk); #1;
            chk_all("reset_held", 1'b0, 4'b0000, 1'b0);
        end

        // Release between edges; outputs stay at reset until the next edge.
        @(negedge clk);
        a = 0; b = 0; c = 0; d = 0; va = 4'b0000; vb = 4'b0000;
        rst_n = 1'b1;
        prev_y = 1'b0; prev_vy = 4'b0000; prev_vp = 1'b0;

        // Directed table: check nothing moves before the edge, then the result.
        foreach (tbl[k]) begin
            apply(tbl[k].a, tbl[k].b, tbl[k].c, tbl[k].d, tbl[k].va, tbl[k].vb);
            #1;
            chk_all({tbl[k].name, "_pre"}, prev_y, prev_vy, prev_vp);
            @(posedge clk); #1;
            chk_all(tbl[k].name, tbl[k].exp_y, tbl[k].exp_vy, tbl[k].exp_vp);
            prev_y = tbl[k].exp_y; prev_vy = tbl[k].exp_vy; prev_vp = tbl[k].exp_vp;
            if (tbl[k].name == "vec_mask") begin
                chk("vec_mask.vy0", 32'(vy[0]), 32'd1);
                chk("vec_mask.vy3", 32'(vy[3]), 32'd0);
            end
        end

        // Mid-run reset shorter than half a cycle.
        apply(1, 1, 0, 0, 4'b1111, 4'b1111);
        @(posedge clk);
        @(posedge clk); #1;
        chk_all("midrst_before", 1'b1, 4'b1111, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk_all("midrst_async", 1'b0, 4'b0000, 1'b0);
        #2 rst_n = 1'b1;
        #1;
        chk_all("midrst_released", 1'b0, 4'b0000, 1'b0);
        @(posedge clk); #1;
        chk_all("midrst_reload", 1'b1, 4'b1111, 1'b0);

        // Input wiggles between edges do not reach the outputs.
        @(negedge clk);
        a = 0; va = 4'b0000;
        #1 a = 1; va = 4'b1111;
        #1;
        chk_all("glitch_hold", 1'b1, 4'b1111, 1'b0);

        // Random stimulus against the model.
        for (int n = 0; n < 200; n++) begin
            logic ra, rb, rc, rd;
            logic [3:0] rva, rvb;
            ra = 1'($urandom); rb = 1'($urandom); rc = 1'($urandom); rd = 1'($urandom);
            rva = 4'($urandom); rvb = 4'($urandom);
            apply(ra, rb, rc, rd, rva, rvb);
            my  = model_y(ra, rb, rc, rd);
            mvy = rva & rvb;
            @(posedge clk); #1;
            chk_all("random", my, mvy, model_vp(mvy));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_behav_gate
